// File: rtl/l2_sched.sv
`timescale 1ns/1ps
// l2_sched: frame-level scheduler for CNN layer 2.
// Issues one layer start per window and drives the upstream tap stream in lock-step.
// Counts conv results and pooled words, then clears the layer at frame end.
// Frame completion and protocol errors are reported to the top-level controller.
module l2_sched #(
  parameter int unsigned NTap    = 10,
  parameter int unsigned NConv   = 144,
  parameter int unsigned NWord   = 144,
  parameter int unsigned DrainTo = 1023
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frm_strt_i,
  input  logic       abort_i,
  input  logic       src_rdy_i,
  output logic       src_adv_o,
  output logic       l2_strt_o,
  input  logic       l2_bsy_i,
  input  logic       pool_vld_i,
  output logic       l2_clr_o,
  output logic       frm_bsy_o,
  output logic       frm_done_o,
  output logic       err_o,
  output logic [7:0] conv_cnt_o
);

  localparam int unsigned TapW   = $clog2(NTap);
  localparam int unsigned WordW  = $clog2(NWord + 1);
  localparam int unsigned DrainW = $clog2(DrainTo + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSrc,
    StIssue,
    StBurst,
    StDrain,
    StClear,
    StDone
  } state_e;

  state_e            state_q;
  logic [7:0]        conv_cnt_q;
  logic [TapW-1:0]   tap_cnt_q;
  logic [WordW-1:0]  word_cnt_q;
  logic [WordW-1:0]  word_cnt_d;
  logic [DrainW-1:0] drain_q;
  logic              err_q;

  logic word_full;
  logic word_ovf;
  logic word_done;
  logic abort_ok;

  assign word_full = (word_cnt_q == WordW'(NWord));
  assign abort_ok  = abort_i && (state_q != StIdle) && (state_q != StClear)
                     && (state_q != StDone);

  // Saturating pooled-word count; a word beyond a full frame is an overrun.
  always_comb begin
    word_cnt_d = word_cnt_q;
    word_ovf   = 1'b0;
    if ((state_q != StIdle) && pool_vld_i) begin
      if (word_full) begin
        word_ovf = 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + WordW'(1);
      end
    end
    word_done = (word_cnt_d == WordW'(NWord));
  end

  // Frame sequencer: state, counters and the sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      conv_cnt_q <= '0;
      tap_cnt_q  <= '0;
      word_cnt_q <= '0;
      drain_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      if (word_ovf) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (frm_strt_i) begin
            state_q    <= StWaitSrc;
            conv_cnt_q <= '0;
            tap_cnt_q  <= '0;
            word_cnt_q <= '0;
            drain_q    <= '0;
            err_q      <= 1'b0;
          end
        end
        StWaitSrc: begin
          if (conv_cnt_q == 8'(NConv)) begin
            state_q <= StDrain;
            drain_q <= '0;
          end else if (src_rdy_i && !l2_bsy_i) begin
            state_q <= StIssue;
          end
        end
        StIssue: begin
          tap_cnt_q <= '0;
          state_q   <= StBurst;
        end
        StBurst: begin
          // ISSUE advanced tap 0, so the burst covers the remaining NTap-1 taps.
          if (!l2_bsy_i) begin
            err_q <= 1'b1;
          end
          if (tap_cnt_q == TapW'(NTap - 2)) begin
            conv_cnt_q <= conv_cnt_q + 8'd1;
            state_q    <= StWaitSrc;
          end else begin
            tap_cnt_q <= tap_cnt_q + TapW'(1);
          end
        end
        StDrain: begin
          drain_q <= drain_q + DrainW'(1);
          if (word_done) begin
            state_q <= StClear;
          end else if (drain_q == DrainW'(DrainTo - 1)) begin
            state_q <= StClear;
            err_q   <= 1'b1;
          end
        end
        StClear: begin
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // Abort overrides any transition above but keeps counter updates.
      if (abort_ok) begin
        state_q <= StClear;
        err_q   <= 1'b1;
      end
    end
  end

  // Outputs are decoded from the state register only.
  assign src_adv_o  = (state_q == StIssue) || (state_q == StBurst);
  assign l2_strt_o  = (state_q == StIssue);
  assign l2_clr_o   = (state_q == StClear);
  assign frm_done_o = (state_q == StDone);
  assign frm_bsy_o  = (state_q != StIdle);
  assign err_o      = err_q;
  assign conv_cnt_o = conv_cnt_q;

endmodule
